// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared constants, op codes and sequencer state type for the vector datapath
package vec_pkg;

    localparam int LANES  = 16;
    localparam int LANE_W = 8;
    localparam int VEC_W  = LANES * LANE_W;

    localparam logic [2:0] ADDV = 3'b000;
    localparam logic [2:0] SUBV = 3'b001;
    localparam logic [2:0] MULV = 3'b010;
    localparam logic [2:0] XORV = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == ADDV) || (op == SUBV) || (op == MULV) || (op == XORV);
    endfunction

endpackage

// File: rtl/vec_slice_mux.sv
// rtl/vec_slice_mux.sv - selects one SLICE_W-wide slice of a vector operand
module vec_slice_mux #(
    parameter int VEC_W   = 128,
    parameter int SLICE_W = 32,
    parameter int SEL_W   = 2
) (
    input  logic [VEC_W-1:0]   vec_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [SLICE_W-1:0] slice_o
);

    localparam int NSLICE = VEC_W / SLICE_W;

    logic [NSLICE-1:0][SLICE_W-1:0] slices;

    assign slices  = vec_i;
    assign slice_o = slices[sel_i];

endmodule

// File: rtl/vec_alu_sequencer.sv
// rtl/vec_alu_sequencer.sv - walks one vector op through the shared lane ALU, SLICE lanes per cycle
module vec_alu_sequencer
    import vec_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Start,
    input  logic                    Flush,
    input  logic [2:0]              ALUControl,
    input  logic [VEC_W-1:0]        SrcA,
    input  logic [VEC_W-1:0]        SrcB,
    output logic                    Stall,
    output logic                    Done,
    output logic                    Err,
    output logic [VEC_W-1:0]        Result,
    output logic [SLICE*LANE_W-1:0] LaneA,
    output logic [SLICE*LANE_W-1:0] LaneB,
    output logic [2:0]              LaneCtrl,
    input  logic [SLICE*LANE_W-1:0] LaneY
);

    localparam int NSLICE  = LANES / SLICE;
    localparam int SLICE_W = SLICE * LANE_W;
    localparam int CNT_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    seq_state_t                     state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [VEC_W-1:0]               a_q, a_d;
    logic [VEC_W-1:0]               b_q, b_d;
    logic [2:0]                     op_q, op_d;
    logic [NSLICE-1:0][SLICE_W-1:0] result_q, result_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;

    logic                           accept;
    logic                           legal;
    logic [SLICE_W-1:0]             slice_a;
    logic [SLICE_W-1:0]             slice_b;

    assign accept = Start & ~Flush;
    assign legal  = op_legal(op_q);

    vec_slice_mux #(.VEC_W(VEC_W), .SLICE_W(SLICE_W), .SEL_W(CNT_W)) u_mux_a (
        .vec_i   (a_q),
        .sel_i   (cnt_q),
        .slice_o (slice_a)
    );

    vec_slice_mux #(.VEC_W(VEC_W), .SLICE_W(SLICE_W), .SEL_W(CNT_W)) u_mux_b (
        .vec_i   (b_q),
        .sel_i   (cnt_q),
        .slice_o (slice_b)
    );

    // Illegal ops still run the full sequence so Err lines up with a normal Done.
    assign LaneA    = (state_q == RUN) ? slice_a : '0;
    assign LaneB    = (state_q == RUN) ? slice_b : '0;
    assign LaneCtrl = (state_q == RUN && legal) ? op_q : 3'b000;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        Stall    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                Stall   = (state_q == IDLE) & accept;
                state_d = IDLE;
                if (accept) begin
                    a_d     = SrcA;
                    b_d     = SrcB;
                    op_d    = ALUControl;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                Stall = 1'b1;
                if (Flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    result_d[cnt_q] = legal ? LaneY : '0;
                    cnt_d           = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = ~legal;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign Done   = done_q;
    assign Err    = err_q;
    assign Result = result_q;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// tb/tb_vec_alu_sequencer.sv - self-checking bench with lane ALU model and vector reference
module tb_vec_alu_sequencer;
    import vec_pkg::*;

    localparam int SLICE   = 4;
    localparam int NSLICE  = LANES / SLICE;
    localparam int SLICE_W = SLICE * LANE_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               Start;
    logic               Flush;
    logic [2:0]         ALUControl;
    logic [VEC_W-1:0]   SrcA;
    logic [VEC_W-1:0]   SrcB;
    logic               Stall;
    logic               Done;
    logic               Err;
    logic [VEC_W-1:0]   Result;
    logic [SLICE_W-1:0] LaneA;
    logic [SLICE_W-1:0] LaneB;
    logic [2:0]         LaneCtrl;
    logic [SLICE_W-1:0] LaneY;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_alu_sequencer #(.SLICE(SLICE)) dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .Flush      (Flush),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Stall      (Stall),
        .Done       (Done),
        .Err        (Err),
        .Result     (Result),
        .LaneA      (LaneA),
        .LaneB      (LaneB),
        .LaneCtrl   (LaneCtrl),
        .LaneY      (LaneY)
    );

    function automatic logic [7:0] lane_math(input logic [2:0] op, input int x, input int y);
        int r;
        case (op)
            3'b000:  r = (x + y) % 256;
            3'b001:  r = (x - y + 256) % 256;
            3'b010:  r = (x * y) % 256;
            3'b101:  r = x ^ y;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    // Shared lane ALU the sequencer drives.
    always_comb begin
        LaneY = '0;
        for (int i = 0; i < SLICE; i++)
            LaneY[i*LANE_W +: LANE_W] = lane_math(LaneCtrl, int'(LaneA[i*LANE_W +: LANE_W]),
                                                  int'(LaneB[i*LANE_W +: LANE_W]));
    end

    function automatic logic is_legal(input logic [2:0] op);
        return op == 3'b000 || op == 3'b001 || op == 3'b010 || op == 3'b101;
    endfunction

    function automatic logic [VEC_W-1:0] ref_result(input logic [VEC_W-1:0] a,
                                                     input logic [VEC_W-1:0] b,
                                                     input logic [2:0] op);
        logic [VEC_W-1:0] r;
        r = '0;
        if (is_legal(op))
            for (int i = 0; i < LANES; i++)
                r[i*LANE_W +: LANE_W] = lane_math(op, int'(a[i*LANE_W +: LANE_W]),
                                                  int'(b[i*LANE_W +: LANE_W]));
        return r;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] fill(input logic [7:0] x);
        logic [VEC_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = x;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [VEC_W-1:0] a,
                          input logic [VEC_W-1:0] b, input logic [2:0] op);
        logic [VEC_W-1:0] exp;
        logic [2:0]       exp_ctrl;
        exp      = ref_result(a, b, op);
        exp_ctrl = is_legal(op) ? op : 3'b000;
        SrcA = a; SrcB = b; ALUControl = op; Start = 1'b1; Flush = 1'b0;
        #1;
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL %s accept_stall: got %b expected 1", name, Stall); end
        tick();
        Start = 1'b0; SrcA = rand_vec(); SrcB = rand_vec(); ALUControl = 3'($urandom);
        for (int k = 0; k < NSLICE; k++) begin
            #1;
            checks++;
            if (Stall !== 1'b1 || Done !== 1'b0) begin
                errors++; $display("FAIL %s run_stall_done k=%0d: got %b%b expected 10", name, k, Stall, Done);
            end
            checks++;
            if (LaneCtrl !== exp_ctrl) begin
                errors++; $display("FAIL %s lanectrl k=%0d: got %b expected %b", name, k, LaneCtrl, exp_ctrl);
            end
            checks++;
            if (LaneA !== a[k*SLICE_W +: SLICE_W] || LaneB !== b[k*SLICE_W +: SLICE_W]) begin
                errors++; $display("FAIL %s lane_slice k=%0d: got %h/%h expected %h/%h", name, k,
                                   LaneA, LaneB, a[k*SLICE_W +: SLICE_W], b[k*SLICE_W +: SLICE_W]);
            end
            tick();
        end
        checks++;
        if (Done !== 1'b1 || Err !== !is_legal(op) || Stall !== 1'b0) begin
            errors++; $display("FAIL %s done_err_stall: got %b%b%b expected 1%b0", name, Done, Err, Stall, !is_legal(op));
        end
        checks++;
        if (Result !== exp) begin
            errors++; $display("FAIL %s result: got %h expected %h", name, Result, exp);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || Err !== 1'b0) begin
            errors++; $display("FAIL %s done_one_cycle: got %b%b expected 00", name, Done, Err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Start = 1'b0; Flush = 1'b0; ALUControl = 3'b000; SrcA = '0; SrcB = '0;
        tick(); tick();
        checks++;
        if ({Stall, Done, Err} !== 3'b000 || Result !== '0) begin
            errors++; $display("FAIL reset_outputs: got %b%b%b %h expected 000 0", Stall, Done, Err, Result);
        end
        checks++;
        if (LaneA !== '0 || LaneB !== '0 || LaneCtrl !== 3'b000) begin
            errors++; $display("FAIL reset_lanes: got %h %h %b expected 0 0 000", LaneA, LaneB, LaneCtrl);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_addv();
        logic [VEC_W-1:0] a;
        for (int i = 0; i < LANES; i++) a[i*LANE_W +: LANE_W] = 8'(i + 1);
        run_op("addv", a, fill(8'h01), ADDV);
    endtask

    task automatic test_wrap();
        run_op("subv_wrap", fill(8'h00), fill(8'h01), SUBV);
        run_op("mulv_wrap", fill(8'h10), fill(8'h20), MULV);
        run_op("addv_nocarry", fill(8'hFF), fill(8'h01), ADDV);
    endtask

    task automatic test_random();
        logic [2:0] ops [4];
        ops[0] = ADDV; ops[1] = SUBV; ops[2] = MULV; ops[3] = XORV;
        for (int n = 0; n < 16; n++)
            run_op("random", rand_vec(), rand_vec(), ops[$urandom_range(0, 3)]);
    endtask

    task automatic test_illegal();
        logic [2:0] bad [4];
        bad[0] = 3'b111; bad[1] = 3'b011; bad[2] = 3'b100; bad[3] = 3'b110;
        for (int n = 0; n < 4; n++) run_op("illegal", rand_vec(), rand_vec(), bad[n]);
    endtask

    task automatic test_flush();
        SrcA = rand_vec(); SrcB = rand_vec(); ALUControl = ADDV; Start = 1'b1; Flush = 1'b0;
        tick();
        Start = 1'b0;
        tick();
        Flush = 1'b1; Start = 1'b1; ALUControl = XORV; SrcA = rand_vec();
        #1;
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL flush_run_stall: got %b expected 1", Stall); end
        tick();
        checks++;
        if ({Stall, Done, Err} !== 3'b000 || LaneA !== '0) begin
            errors++; $display("FAIL flush_idle: got %b%b%b %h expected 000 0", Stall, Done, Err, LaneA);
        end
        tick();
        Flush = 1'b0; Start = 1'b0;
        #1;
        checks++;
        if (Stall !== 1'b0 || LaneCtrl !== 3'b000) begin
            errors++; $display("FAIL flush_start_rejected: got %b %b expected 0 000", Stall, LaneCtrl);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (Done !== 1'b0 || Err !== 1'b0) begin
                errors++; $display("FAIL flush_no_done k=%0d: got %b%b expected 00", k, Done, Err);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [VEC_W-1:0] a1, b1;
        a1 = rand_vec(); b1 = rand_vec();
        SrcA = a1; SrcB = b1; ALUControl = ADDV; Start = 1'b1; Flush = 1'b0;
        tick();
        SrcA = fill(8'hAA); SrcB = fill(8'hFF); ALUControl = XORV;
        tick();
        checks++;
        if (LaneCtrl !== ADDV) begin errors++; $display("FAIL b2b_start_ignored: got %b expected 000", LaneCtrl); end
        tick(); tick(); tick();
        checks++;
        if (Done !== 1'b1 || Stall !== 1'b0 || Result !== ref_result(a1, b1, ADDV)) begin
            errors++; $display("FAIL b2b_first: got %b%b %h expected 10 %h", Done, Stall, Result, ref_result(a1, b1, ADDV));
        end
        tick();
        Start = 1'b0; SrcA = rand_vec();
        checks++;
        if (Stall !== 1'b1 || LaneCtrl !== XORV || LaneA !== fill(8'hAA) >> (VEC_W - SLICE_W)) begin
            errors++; $display("FAIL b2b_second_run: got %b %b %h expected 1 101 aaaaaaaa", Stall, LaneCtrl, LaneA);
        end
        for (int k = 0; k < NSLICE - 1; k++) begin
            tick();
            checks++;
            if (Done !== 1'b0) begin errors++; $display("FAIL b2b_early_done k=%0d: got %b expected 0", k, Done); end
        end
        tick();
        checks++;
        if (Done !== 1'b1 || Err !== 1'b0 || Result !== fill(8'h55)) begin
            errors++; $display("FAIL b2b_second: got %b%b %h expected 10 %h", Done, Err, Result, fill(8'h55));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        SrcA = rand_vec(); SrcB = rand_vec(); ALUControl = MULV; Start = 1'b1; Flush = 1'b0;
        tick();
        Start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({Stall, Done, Err} !== 3'b000 || Result !== '0) begin
            errors++; $display("FAIL midreset_outputs: got %b%b%b %h expected 000 0", Stall, Done, Err, Result);
        end
        checks++;
        if (LaneA !== '0 || LaneB !== '0 || LaneCtrl !== 3'b000) begin
            errors++; $display("FAIL midreset_lanes: got %h %h %b expected 0 0 000", LaneA, LaneB, LaneCtrl);
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (Done !== 1'b0) begin errors++; $display("FAIL midreset_no_done k=%0d: got %b expected 0", k, Done); end
        end
        run_op("after_reset", rand_vec(), rand_vec(), XORV);
    endtask

    initial begin
        test_reset();
        test_addv();
        test_wrap();
        test_random();
        test_illegal();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
